// File: rtl/output_stage.sv
// Frame output stage: reads one entry from the frame FIFO and serialises its payload as 16-bit words
// on a one-hot channel, with ready/valid backpressure. Optional even parity on dout via OUTPUT_STAGE_PARITY_EN.
module output_stage (
  input  logic         clk_in,
  input  logic         rst_n,
  input  logic         fifo_empty,
  output logic         fifo_r_enable,
  input  logic [139:0] data_from_fifo,
  input  logic         out_ready,
  output logic [15:0]  dout,
  output logic [7:0]   dout_vld,
  output logic         frame_end,
  output logic         ch_err,
  output logic         dout_par
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    LOAD = 2'd2,
    SEND = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [127:0] shift_q, shift_d;
  logic [3:0]   remaining_q, remaining_d;
  logic [7:0]   chan_q, chan_d;
  logic         rd_en_q, rd_en_d;
  logic         ch_err_q, ch_err_d;

  logic [127:0] entry_payload;
  logic [7:0]   entry_ch;
  logic [3:0]   entry_len;
  logic         entry_onehot;
  logic         xfer;

  assign entry_payload = data_from_fifo[139:12];
  assign entry_ch      = data_from_fifo[11:4];
  assign entry_len     = data_from_fifo[3:0];
  assign entry_onehot  = (entry_ch != 8'h00) && ((entry_ch & (entry_ch - 8'd1)) == 8'h00);
  assign xfer          = (state_q == SEND) && out_ready;

  // State register
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (!fifo_empty) state_d = WAIT;
      WAIT: state_d = LOAD;
      LOAD: state_d = entry_onehot ? SEND : IDLE;
      SEND: if (out_ready && (remaining_q == 4'd1)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered strobes
  always_comb begin
    shift_d     = shift_q;
    remaining_d = remaining_q;
    chan_d      = chan_q;
    rd_en_d     = (state_q == IDLE) && !fifo_empty;
    ch_err_d    = (state_q == LOAD) && !entry_onehot;
    if ((state_q == LOAD) && entry_onehot) begin
      shift_d     = entry_payload;
      remaining_d = (entry_len == 4'd0) ? 4'd8 : entry_len;
      chan_d      = entry_ch;
    end else if (xfer) begin
      shift_d     = {shift_q[111:0], 16'h0000};
      remaining_d = remaining_q - 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= '0;
      remaining_q <= '0;
      chan_q      <= '0;
      rd_en_q     <= 1'b0;
      ch_err_q    <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      remaining_q <= remaining_d;
      chan_q      <= chan_d;
      rd_en_q     <= rd_en_d;
      ch_err_q    <= ch_err_d;
    end
  end

  // Outputs decoded from registers only; reset forces IDLE so they clear at once
  always_comb begin
    fifo_r_enable = rd_en_q;
    ch_err        = ch_err_q;
    dout          = 16'h0000;
    dout_vld      = 8'h00;
    frame_end     = 1'b0;
    if (state_q == SEND) begin
      dout      = shift_q[127:112];
      dout_vld  = chan_q;
      frame_end = (remaining_q == 4'd1);
    end
  end

`ifdef OUTPUT_STAGE_PARITY_EN
  assign dout_par = (dout_vld != 8'h00) ? ^dout : 1'b0;
`else
  assign dout_par = 1'b0;
`endif

endmodule

// File: tb/tb_output_stage.sv
// Self-checking bench for output_stage: FIFO model plus scoreboard of expected words,
// compared whenever the DUT presents a word.
module tb_output_stage;

`ifdef OUTPUT_STAGE_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic         clk_in;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_r_enable;
  logic [139:0] data_from_fifo;
  logic         out_ready;
  logic [15:0]  dout;
  logic [7:0]   dout_vld;
  logic         frame_end;
  logic         ch_err;
  logic         dout_par;

  typedef struct packed {
    logic [15:0] w;
    logic [7:0]  ch;
    logic        fe;
  } exp_t;

  exp_t         exp_q[$];
  logic [139:0] entry_mem [0:63];
  int           push_cnt = 0;
  int           pop_cnt  = 0;
  int           rd_count = 0;
  int           tests    = 0;
  int           fails    = 0;

  output_stage dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_r_enable  (fifo_r_enable),
    .data_from_fifo (data_from_fifo),
    .out_ready      (out_ready),
    .dout           (dout),
    .dout_vld       (dout_vld),
    .frame_end      (frame_end),
    .ch_err         (ch_err),
    .dout_par       (dout_par)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  assign fifo_empty = (push_cnt == pop_cnt);

  // FIFO model: a read strobe seen during WAIT makes the entry available for LOAD
  initial begin
    data_from_fifo = '0;
    forever begin
      @(negedge clk_in);
      if (fifo_r_enable === 1'b1) begin
        data_from_fifo = entry_mem[pop_cnt];
        pop_cnt++;
        rd_count++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

  task automatic push_frame(input logic [127:0] p, input logic [7:0] ch, input logic [3:0] len, input bit good);
    int n;
    n = (len == 4'd0) ? 8 : int'(len);
    entry_mem[push_cnt] = {p, ch, len};
    push_cnt++;
    if (good)
      for (int k = 0; k < n; k++)
        exp_q.push_back(exp_t'{p[127-16*k -: 16], ch, (k == n - 1)});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk_in);
    tests++;
    if ({fifo_r_enable, dout, dout_vld, frame_end, ch_err, dout_par} !== 28'h0) begin
      fails++;
      $display("FAIL reset_outputs got=%h required=0", {fifo_r_enable, dout, dout_vld, frame_end, ch_err, dout_par});
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk_in);
    tests++;
    if (rd_count !== 0 || fifo_r_enable !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle_no_read reads=%0d rd_en=%b required 0/0", rd_count, fifo_r_enable);
    end
  endtask

  task automatic test_single_word();
    int first, last, rd0;
    logic [127:0] p;
    p = '0;
    p[127:112] = 16'hABCD;
    first = -1; last = -1; rd0 = rd_count;
    @(negedge clk_in);
    out_ready = 1'b1;
    push_frame(p, 8'h04, 4'd1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      if (dout_vld != 8'h00) begin
        if (first < 0) first = c;
        last = c;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL single_extra dout=%h required no word", dout);
        end else begin
          if ({dout, dout_vld, frame_end} !== {exp_q[0].w, exp_q[0].ch, exp_q[0].fe} ||
              dout_par !== (PAR_EN & ^exp_q[0].w)) begin
            fails++;
            $display("FAIL single_word got=%h/%h/%b/%b required=%h/%h/%b/%b", dout, dout_vld, frame_end, dout_par,
                     exp_q[0].w, exp_q[0].ch, exp_q[0].fe, PAR_EN & ^exp_q[0].w);
          end
          void'(exp_q.pop_front());
        end
      end else begin
        tests++;
        if (dout !== 16'h0 || frame_end !== 1'b0 || dout_par !== 1'b0) begin
          fails++;
          $display("FAIL single_idle_outputs dout=%h fe=%b par=%b required 0", dout, frame_end, dout_par);
        end
      end
    end
    tests++;
    if (first != 3 || last != 3 || exp_q.size() != 0 || rd_count - rd0 != 1) begin
      fails++;
      $display("FAIL single_timing first=%0d last=%0d left=%0d reads=%0d required 3/3/0/1",
               first, last, exp_q.size(), rd_count - rd0);
    end
  endtask

  task automatic test_full_frame();
    int first, last, rd0;
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[127-16*k -: 16] = 16'(k + 1);
    first = -1; last = -1; rd0 = rd_count;
    @(negedge clk_in);
    out_ready = 1'b1;
    push_frame(p, 8'h80, 4'd0, 1'b1);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk_in);
      if (dout_vld != 8'h00) begin
        if (first < 0) first = c;
        last = c;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL full_extra dout=%h required no word", dout);
        end else begin
          if ({dout, dout_vld, frame_end} !== {exp_q[0].w, exp_q[0].ch, exp_q[0].fe} ||
              dout_par !== (PAR_EN & ^exp_q[0].w)) begin
            fails++;
            $display("FAIL full_word got=%h/%h/%b/%b required=%h/%h/%b/%b", dout, dout_vld, frame_end, dout_par,
                     exp_q[0].w, exp_q[0].ch, exp_q[0].fe, PAR_EN & ^exp_q[0].w);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    tests++;
    if (first != 3 || last != 10 || exp_q.size() != 0 || rd_count - rd0 != 1) begin
      fails++;
      $display("FAIL full_timing first=%0d last=%0d left=%0d reads=%0d required 3/10/0/1",
               first, last, exp_q.size(), rd_count - rd0);
    end
  endtask

  task automatic test_backpressure();
    int first, last, idx, hold, stall_left;
    logic [127:0] p;
    p = '0;
    p[127:80] = {16'h1111, 16'h2222, 16'h3333};
    first = -1; last = -1; idx = 0; hold = 0; stall_left = 5;
    @(negedge clk_in);
    out_ready = 1'b1;
    push_frame(p, 8'h10, 4'd3, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_in);
      out_ready = 1'b1;
      if (dout_vld != 8'h00) begin
        if (first < 0) first = c;
        last = c;
        if (idx == 1) hold++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL bp_extra dout=%h required no word", dout);
        end else begin
          if ({dout, dout_vld, frame_end} !== {exp_q[0].w, exp_q[0].ch, exp_q[0].fe}) begin
            fails++;
            $display("FAIL bp_word cycle=%0d got=%h/%h/%b required=%h/%h/%b", c, dout, dout_vld, frame_end,
                     exp_q[0].w, exp_q[0].ch, exp_q[0].fe);
          end
          if (idx == 1 && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
          end else begin
            void'(exp_q.pop_front());
            idx++;
          end
        end
      end
      if (c == 11) begin
        tests++;
        if (dout_vld !== 8'h00) begin
          fails++;
          $display("FAIL bp_end_idle dout_vld=%h required 00", dout_vld);
        end
      end
    end
    out_ready = 1'b1;
    tests++;
    if (first != 3 || last != 10 || hold != 6 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bp_timing first=%0d last=%0d hold=%0d left=%0d required 3/10/6/0",
               first, last, hold, exp_q.size());
    end
  endtask

  task automatic test_bad_channel();
    int errs, err1, err2, first;
    logic [127:0] p;
    p = '0;
    p[127:112] = 16'h600D;
    errs = 0; err1 = -1; err2 = -1; first = -1;
    @(negedge clk_in);
    out_ready = 1'b1;
    push_frame({8{16'hBAD0}}, 8'h03, 4'd2, 1'b0);
    push_frame({8{16'hBAD1}}, 8'h00, 4'd2, 1'b0);
    push_frame(p, 8'h01, 4'd1, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_in);
      if (ch_err === 1'b1) begin
        errs++;
        if (err1 < 0) err1 = c; else err2 = c;
      end
      if (dout_vld != 8'h00) begin
        if (first < 0) first = c;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL bad_extra dout=%h vld=%h required no word", dout, dout_vld);
        end else begin
          if ({dout, dout_vld, frame_end} !== {exp_q[0].w, exp_q[0].ch, exp_q[0].fe}) begin
            fails++;
            $display("FAIL bad_next_word got=%h/%h/%b required=%h/%h/%b", dout, dout_vld, frame_end,
                     exp_q[0].w, exp_q[0].ch, exp_q[0].fe);
          end
          void'(exp_q.pop_front());
        end
      end
    end
    tests++;
    if (errs != 2 || err1 != 3 || err2 != 6 || first != 9 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL bad_channel errs=%0d at %0d,%0d first_word=%0d left=%0d required 2 at 3,6 first 9 left 0",
               errs, err1, err2, first, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int nw, rd0;
    int vcyc [0:3];
    logic [127:0] pa, pb;
    pa = '0; pb = '0;
    pa[127:96] = {16'h0007, 16'h0003};
    pb[127:112] = 16'h8001;
    nw = 0; rd0 = rd_count;
    @(negedge clk_in);
    out_ready = 1'b1;
    push_frame(pa, 8'h02, 4'd2, 1'b1);
    push_frame(pb, 8'h40, 4'd1, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_in);
      if (dout_vld != 8'h00) begin
        if (nw < 4) vcyc[nw] = c;
        nw++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL b2b_extra dout=%h required no word", dout);
        end else begin
          if ({dout, dout_vld, frame_end} !== {exp_q[0].w, exp_q[0].ch, exp_q[0].fe} ||
              dout_par !== (PAR_EN & ^exp_q[0].w)) begin
            fails++;
            $display("FAIL b2b_word got=%h/%h/%b/%b required=%h/%h/%b/%b", dout, dout_vld, frame_end, dout_par,
                     exp_q[0].w, exp_q[0].ch, exp_q[0].fe, PAR_EN & ^exp_q[0].w);
          end
          void'(exp_q.pop_front());
        end
      end else begin
        tests++;
        if (dout_par !== 1'b0) begin
          fails++;
          $display("FAIL b2b_idle_parity dout_par=%b required 0", dout_par);
        end
      end
    end
    tests++;
    if (nw != 3 || vcyc[0] != 3 || vcyc[1] != 4 || vcyc[2] != 8 || rd_count - rd0 != 2) begin
      fails++;
      $display("FAIL b2b_timing words=%0d cycles=%0d,%0d,%0d reads=%0d required 3 at 3,4,8 reads 2",
               nw, vcyc[0], vcyc[1], vcyc[2], rd_count - rd0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int idx, rd0, first;
    bit hit;
    logic [127:0] p;
    for (int k = 0; k < 8; k++) p[127-16*k -: 16] = 16'hC000 + 16'(k);
    idx = 0; hit = 0; rd0 = rd_count;
    @(negedge clk_in);
    out_ready = 1'b1;
    push_frame(p, 8'h08, 4'd8, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk_in);
      if (dout_vld != 8'h00) begin
        if (idx == 2) begin
          hit = 1;
          tests++;
          if (dout !== 16'hC002) begin
            fails++;
            $display("FAIL rst_mid_word3 dout=%h required c002", dout);
          end
          rst_n = 1'b0;
          #1;
          tests++;
          if ({fifo_r_enable, dout, dout_vld, frame_end, ch_err, dout_par} !== 28'h0) begin
            fails++;
            $display("FAIL rst_mid_outputs got=%h required=0",
                     {fifo_r_enable, dout, dout_vld, frame_end, ch_err, dout_par});
          end
          break;
        end
        void'(exp_q.pop_front());
        idx++;
      end
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL rst_mid_reach word3 not reached, required within 12 cycles");
    end
    exp_q.delete();
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk_in);
      tests++;
      if (dout_vld !== 8'h00 || dout !== 16'h0) begin
        fails++;
        $display("FAIL rst_mid_no_more dout=%h vld=%h required 0/00", dout, dout_vld);
      end
    end
    tests++;
    if (rd_count - rd0 != 1) begin
      fails++;
      $display("FAIL rst_mid_reread reads=%0d required 1", rd_count - rd0);
    end
    p = '0;
    p[127:112] = 16'h5A5A;
    first = -1;
    push_frame(p, 8'h01, 4'd1, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk_in);
      if (dout_vld != 8'h00 && exp_q.size() != 0) begin
        if (first < 0) first = c;
        tests++;
        if ({dout, dout_vld, frame_end} !== {exp_q[0].w, exp_q[0].ch, exp_q[0].fe}) begin
          fails++;
          $display("FAIL rst_fresh_word got=%h/%h/%b required=%h/%h/%b", dout, dout_vld, frame_end,
                   exp_q[0].w, exp_q[0].ch, exp_q[0].fe);
        end
        void'(exp_q.pop_front());
      end
    end
    tests++;
    if (first != 3 || exp_q.size() != 0) begin
      fails++;
      $display("FAIL rst_fresh_timing first=%0d left=%0d required 3/0", first, exp_q.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    test_reset();
    test_single_word();
    test_full_frame();
    test_backpressure();
    test_bad_channel();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
